xcvr_link_supervisor: RTL

Link bring-up and recovery sequencer for a single-channel 10G transceiver. It drives the `reset` input of the transceiver reset controller and watches that controller's `tx_ready`/`rx_ready` and the PHY's `rx_is_lockedtodata`. It bounds each bring-up phase with timeouts and retries a failed bring-up a limited number of times. It re-runs the reset sequence when an established link is lost, and reports link state and statistics to the AFU CSR block.

---
 rtl/xcvr_link_supervisor.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/xcvr_link_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : xcvr_link_supervisor
// Purpose  : Link bring-up and recovery sequencer for a single-channel 10G
//            transceiver. Pulses the reset controller, waits for TX and RX
//            readiness with bounded timeouts, retries a failed bring-up a
//            limited number of times, and re-runs the sequence when an
//            established link is lost for long enough.
// Ports    : clock, reset (async, active-high), enable (link wanted),
//            tx_ready / rx_ready / rx_is_lockedtodata (raw status, synchronized
//            here), xcvr_reset (to reset controller), link_up, link_error,
//            state[2:0], retry_count[3:0], relink_count[15:0].
// Revision : 1.0 - initial release
// ============================================================================
module xcvr_link_supervisor #(
    parameter int RESET_PULSE_CYCLES = 16,
    parameter int TX_TIMEOUT_CYCLES  = 100000,
    parameter int RX_TIMEOUT_CYCLES  = 100000,
    parameter int LOSS_FILTER_CYCLES = 64,
    parameter int MAX_RETRIES        = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        tx_ready,
    input  logic        rx_ready,
    input  logic        rx_is_lockedtodata,
    output logic        xcvr_reset,
    output logic        link_up,
    output logic        link_error,
    output logic [2:0]  state,
    output logic [3:0]  retry_count,
    output logic [15:0] relink_count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RST     = 3'd1,
        ST_WAIT_TX = 3'd2,
        ST_WAIT_RX = 3'd3,
        ST_UP      = 3'd4,
        ST_FAIL    = 3'd5
    } state_t;

    // Timer must cover the longest phase it bounds.
    localparam int c_TMAX0 = (TX_TIMEOUT_CYCLES > RX_TIMEOUT_CYCLES) ? TX_TIMEOUT_CYCLES : RX_TIMEOUT_CYCLES;
    localparam int c_TMAX  = (c_TMAX0 > RESET_PULSE_CYCLES) ? c_TMAX0 : RESET_PULSE_CYCLES;
    localparam int c_TW    = $clog2(c_TMAX + 1);
    localparam int c_LW    = $clog2(LOSS_FILTER_CYCLES + 1);

    localparam logic [c_TW-1:0] c_RST_LAST = c_TW'(RESET_PULSE_CYCLES - 1);
    localparam logic [c_TW-1:0] c_TX_LAST  = c_TW'(TX_TIMEOUT_CYCLES - 1);
    localparam logic [c_TW-1:0] c_RX_LAST  = c_TW'(RX_TIMEOUT_CYCLES - 1);
    localparam logic [c_LW-1:0] c_LOSS_LAST = c_LW'(LOSS_FILTER_CYCLES - 1);
    localparam logic [3:0]      c_MAX_RETRY = 4'(MAX_RETRIES);

    // Two-flop synchronizers for the asynchronous status inputs
    logic r_tx_meta, r_rx_meta, r_lock_meta;
    logic r_tx_s, r_rx_s, r_lock_s;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx_meta   <= 1'b0;
            r_rx_meta   <= 1'b0;
            r_lock_meta <= 1'b0;
            r_tx_s      <= 1'b0;
            r_rx_s      <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_tx_meta   <= tx_ready;
            r_rx_meta   <= rx_ready;
            r_lock_meta <= rx_is_lockedtodata;
            r_tx_s      <= r_tx_meta;
            r_rx_s      <= r_rx_meta;
            r_lock_s    <= r_lock_meta;
        end
    end

    logic w_rx_good;
    logic w_link_good;
    assign w_rx_good   = r_rx_s & r_lock_s;
    assign w_link_good = r_tx_s & w_rx_good;

    state_t          r_state;
    state_t          w_next;
    logic            w_timeout;
    logic            w_relink;
    logic [c_TW-1:0] r_timer;
    logic [c_LW-1:0] r_loss;
    logic [3:0]      r_retry;
    logic [15:0]     r_relink_count;
    logic            r_xcvr_reset;
    logic            r_link_up;
    logic            r_link_error;

    // Next-state decision. Ready is tested before the timeout so a ready
    // arriving on the last allowed cycle still wins.
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        w_relink  = 1'b0;
        if (!enable) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    w_next = ST_RST;
                ST_RST:     if (r_timer == c_RST_LAST) w_next = ST_WAIT_TX;
                ST_WAIT_TX: begin
                    if (r_tx_s)                      w_next    = ST_WAIT_RX;
                    else if (r_timer == c_TX_LAST)   w_timeout = 1'b1;
                end
                ST_WAIT_RX: begin
                    if (w_rx_good)                   w_next    = ST_UP;
                    else if (r_timer == c_RX_LAST)   w_timeout = 1'b1;
                end
                ST_UP: begin
                    // Counter holds at most LOSS-1; the next bad cycle is the
                    // LOSS-th consecutive one and triggers the relink.
                    if (!w_link_good && (r_loss == c_LOSS_LAST)) begin
                        w_relink = 1'b1;
                        w_next   = ST_RST;
                    end
                end
                ST_FAIL:    w_next = ST_FAIL;
                default:    w_next = ST_IDLE;
            endcase
            if (w_timeout) begin
                w_next = (r_retry == c_MAX_RETRY) ? ST_FAIL : ST_RST;
            end
        end
    end

    // Outputs are decoded from the next state so they change in the same
    // cycle the new state is entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_timer        <= '0;
            r_loss         <= '0;
            r_retry        <= 4'd0;
            r_relink_count <= 16'd0;
            r_xcvr_reset   <= 1'b1;
            r_link_up      <= 1'b0;
            r_link_error   <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_timer      <= (w_next != r_state) ? '0 : r_timer + c_TW'(1);
            r_xcvr_reset <= (w_next == ST_IDLE) || (w_next == ST_RST) || (w_next == ST_FAIL);
            r_link_up    <= (w_next == ST_UP);
            r_link_error <= (w_next == ST_FAIL);

            if ((w_next == ST_IDLE) || (w_next == ST_UP)) begin
                r_retry <= 4'd0;
            end else if (w_timeout && (w_next == ST_RST)) begin
                r_retry <= r_retry + 4'd1;
            end

            if ((r_state == ST_UP) && (w_next == ST_UP)) begin
                r_loss <= w_link_good ? '0 : r_loss + c_LW'(1);
            end else begin
                r_loss <= '0;
            end

            if (w_relink && (r_relink_count != 16'hFFFF)) begin
                r_relink_count <= r_relink_count + 16'd1;
            end
        end
    end

    assign state        = r_state;
    assign xcvr_reset   = r_xcvr_reset;
    assign link_up      = r_link_up;
    assign link_error   = r_link_error;
    assign retry_count  = r_retry;
    assign relink_count = r_relink_count;

endmodule
`default_nettype wire
